bp_be_prefetch_scheduler: RTL

BP_BE_PREFETCH_SCHEDULER -- requirements
Module: bp_be_prefetch_scheduler

---
 rtl/bp_be_prefetch_scheduler_pkg.sv | 21 ++
 rtl/bp_be_prefetch_scheduler_if.sv | 61 ++++++
 rtl/bsg_arb_round_robin.sv | 51 +++++
 rtl/bp_be_prefetch_scheduler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bp_be_prefetch_scheduler_pkg.sv
// Shared types for the backend prefetch scheduler: processor configuration,
// output-buffer FSM states and the dispatch packet width.
package bp_be_prefetch_scheduler_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg,
    e_bp_sv48_cfg
  } bp_params_e;

  typedef enum logic [0:0] {
    e_pf_empty,
    e_pf_hold
  } pf_state_e;

  localparam int dispatch_pkt_width_gp = 64;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 48 : 39;
  endfunction

endpackage

// File: rtl/bp_be_prefetch_scheduler_if.sv
// Trigger, generator and dispatch signalling between the prefetch scheduler
// and its environment; slave is the scheduler side.
interface bp_be_prefetch_scheduler_if
  import bp_be_prefetch_scheduler_pkg::*;
  #(parameter int num_gen_p      = 2,
    parameter int vaddr_width_p  = 39,
    parameter int stride_width_p = 8,
    parameter int loop_range_p   = 8,
    parameter int pkt_width_p    = dispatch_pkt_width_gp)
  ();

  logic                           trig_v_i;
  logic                           trig_ready_and_o;
  logic [vaddr_width_p-1:0]       trig_pc_i;
  logic [vaddr_width_p-1:0]       trig_eff_addr_i;
  logic [stride_width_p-1:0]      trig_stride_i;
  logic [loop_range_p-1:0]        trig_loop_i;

  logic [num_gen_p-1:0]           gen_v_o;
  logic [num_gen_p-1:0]           gen_ready_and_i;
  logic [vaddr_width_p-1:0]       gen_pc_o;
  logic [vaddr_width_p-1:0]       gen_eff_addr_o;
  logic [stride_width_p-1:0]      gen_stride_o;
  logic [loop_range_p-1:0]        gen_loop_o;

  logic [num_gen_p-1:0]           gen_pkt_v_i;
  logic [num_gen_p-1:0]           gen_yumi_o;
  logic [num_gen_p*pkt_width_p-1:0] gen_pkt_i;

  logic                           issue_bubble_i;
  logic                           flush_i;

  logic                           pf_v_o;
  logic                           pf_yumi_i;
  logic [pkt_width_p-1:0]         pf_pkt_o;

  modport slave (
    input  trig_v_i, trig_pc_i, trig_eff_addr_i, trig_stride_i, trig_loop_i,
    output trig_ready_and_o,
    output gen_v_o, gen_pc_o, gen_eff_addr_o, gen_stride_o, gen_loop_o,
    input  gen_ready_and_i,
    input  gen_pkt_v_i, gen_pkt_i,
    output gen_yumi_o,
    input  issue_bubble_i, flush_i,
    output pf_v_o, pf_pkt_o,
    input  pf_yumi_i
  );

  modport master (
    output trig_v_i, trig_pc_i, trig_eff_addr_i, trig_stride_i, trig_loop_i,
    input  trig_ready_and_o,
    input  gen_v_o, gen_pc_o, gen_eff_addr_o, gen_stride_o, gen_loop_o,
    output gen_ready_and_i,
    output gen_pkt_v_i, gen_pkt_i,
    input  gen_yumi_o,
    output issue_bubble_i, flush_i,
    input  pf_v_o, pf_pkt_o,
    output pf_yumi_i
  );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: the requester after the last accepted grant has
// highest priority; the pointer only moves when the grant is consumed.
module bsg_arb_round_robin #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (width_p > 1) ? $clog2(width_p) : 1;

  logic [ptr_w_lp-1:0] ptr_q, ptr_d, grant_idx;
  logic                found;

  // First pass covers indices at or above the pointer, second pass wraps around.
  always_comb begin
    grants_o  = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < width_p; i++) begin
      if (!found && reqs_i[i] && (i >= int'(ptr_q))) begin
        found       = 1'b1;
        grants_o[i] = 1'b1;
        grant_idx   = ptr_w_lp'(i);
      end
    end
    for (int i = 0; i < width_p; i++) begin
      if (!found && reqs_i[i]) begin
        found       = 1'b1;
        grants_o[i] = 1'b1;
        grant_idx   = ptr_w_lp'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i && found) begin
      ptr_d = (int'(grant_idx) == width_p - 1) ? '0 : grant_idx + ptr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_be_prefetch_scheduler.sv
// Routes striding-load triggers to free prefetch generators (filtering repeats
// by PC) and funnels generator packets through a one-entry bubble-waiting buffer.
module bp_be_prefetch_scheduler
  import bp_be_prefetch_scheduler_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int num_gen_p      = 2,
    parameter int loop_range_p   = 8,
    parameter int stride_width_p = 8,
    parameter int starve_limit_p = 16)
  (
    input logic                        clk_i,
    input logic                        reset_n_i,
    bp_be_prefetch_scheduler_if.slave  io
  );

  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p);
  localparam int pkt_w_lp      = dispatch_pkt_width_gp;
  localparam int starve_w_lp   = $clog2(starve_limit_p + 1);

  logic [num_gen_p-1:0]      free, tag_hit, alloc, gen_v, grant;
  logic [num_gen_p-1:0]      tag_v_q;
  logic [vaddr_width_p-1:0]  tag_q [num_gen_p];
  logic                      dup;

  pf_state_e                 state_q;
  logic [starve_w_lp-1:0]    starve_q;
  logic [pkt_w_lp-1:0]       buf_q, cap_pkt;
  logic                      capture, starved, pf_v;

  logic [stride_width_p-1:0] stride_bcast;
  logic [loop_range_p-1:0]   loop_bcast;

  assign free = io.gen_ready_and_i;

  always_comb begin
    tag_hit = '0;
    for (int i = 0; i < num_gen_p; i++) begin
      tag_hit[i] = tag_v_q[i] && (tag_q[i] == io.trig_pc_i);
    end
  end

  assign dup   = |tag_hit;
  assign alloc = free & (~free + num_gen_p'(1));
  assign gen_v = (reset_n_i && io.trig_v_i && !io.flush_i && !dup) ? alloc : '0;

  assign io.trig_ready_and_o = reset_n_i && !io.flush_i && (dup || (|free));
  assign io.gen_v_o          = gen_v;

  // Every generator sees the same payload; only gen_v_o selects the target.
  assign stride_bcast       = io.trig_stride_i;
  assign loop_bcast         = io.trig_loop_i;
  assign io.gen_pc_o        = io.trig_pc_i;
  assign io.gen_eff_addr_o  = io.trig_eff_addr_i;
  assign io.gen_stride_o    = stride_bcast;
  assign io.gen_loop_o      = loop_bcast;

  // A slot's tag stays live while its generator is busy with that trigger.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)      tag_v_q <= '0;
    else if (io.flush_i) tag_v_q <= '0;
    else                 tag_v_q <= gen_v | (tag_v_q & ~free);
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_gen_p; i++) begin
      if (gen_v[i]) tag_q[i] <= io.trig_pc_i;
    end
  end

  bsg_arb_round_robin #(
    .width_p(num_gen_p)
  ) rr_arb (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .reqs_i   (io.gen_pkt_v_i),
    .grants_o (grant),
    .yumi_i   (capture)
  );

  assign capture       = reset_n_i && (state_q == e_pf_empty) && !io.flush_i && (|io.gen_pkt_v_i);
  assign io.gen_yumi_o = capture ? grant : '0;

  always_comb begin
    cap_pkt = '0;
    for (int i = 0; i < num_gen_p; i++) begin
      if (grant[i]) cap_pkt = io.gen_pkt_i[i*pkt_w_lp +: pkt_w_lp];
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) buf_q <= cap_pkt;
  end

  assign starved = (starve_q == starve_w_lp'(starve_limit_p));
  assign pf_v    = reset_n_i && (state_q == e_pf_hold) && (io.issue_bubble_i || starved);

  assign io.pf_v_o   = pf_v;
  assign io.pf_pkt_o = buf_q;

  // Flush wins over everything, including a dispatch handshake in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_pf_empty;
      starve_q <= '0;
    end else if (io.flush_i) begin
      state_q  <= e_pf_empty;
      starve_q <= '0;
    end else begin
      case (state_q)
        e_pf_empty: begin
          starve_q <= '0;
          if (capture) state_q <= e_pf_hold;
        end
        e_pf_hold: begin
          if (io.pf_yumi_i) begin
            state_q  <= e_pf_empty;
            starve_q <= '0;
          end else if (!starved) begin
            starve_q <= starve_q + starve_w_lp'(1);
          end
        end
        default: begin
          state_q  <= e_pf_empty;
          starve_q <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  pf_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) io.pf_yumi_i |-> pf_v);
`endif

endmodule
